// File: rtl/branch_checkpoint_unit.sv
// rtl/branch_checkpoint_unit.sv - branch checkpoint table with registered misprediction recovery
// Define BRANCH_CKPT_STATS_EN to add saturating misprediction / full-stall counters.
module branch_checkpoint_unit #(
    parameter int CKPT_NUM     = 4,
    parameter int AL_SIZE      = 32,
    parameter int PREG_W       = 6,
    parameter int AREG_NUM     = 32,
    parameter int GHR_LEN      = 8,
    parameter int DRAIN_CYCLES = 2,
    localparam int TAG_W = $clog2(AL_SIZE),
    localparam int MAP_W = AREG_NUM * PREG_W,
    localparam int IDX_W = $clog2(CKPT_NUM),
    localparam int CNT_W = $clog2(DRAIN_CYCLES + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                alloc_valid,
    output logic                alloc_ready,
    input  logic [TAG_W-1:0]    alloc_tag,
    input  logic                alloc_color,
    input  logic                alloc_has_ds,
    input  logic [PREG_W-1:0]   alloc_free_head,
    input  logic [MAP_W-1:0]    alloc_map,
    input  logic [GHR_LEN-1:0]  alloc_ghr,
    input  logic                resolve_valid,
    input  logic [TAG_W-1:0]    resolve_tag,
    input  logic                resolve_color,
    input  logic                resolve_mispredict,
    input  logic                flush_all,
    output logic                restore_valid,
    output logic [PREG_W-1:0]   restore_free_head,
    output logic [MAP_W-1:0]    restore_map,
    output logic [GHR_LEN-1:0]  restore_ghr,
    output logic [TAG_W-1:0]    squash_tag,
    output logic                squash_color,
    output logic [TAG_W-1:0]    youngest_ptr,
    output logic                youngest_color,
    output logic                busy,
    output logic [CKPT_NUM-1:0] ckpt_valid
`ifdef BRANCH_CKPT_STATS_EN
    ,
    output logic [31:0]         stat_mispredicts,
    output logic [31:0]         stat_full_stalls
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_RECOVER, S_HOLD} state_t;

    state_t              r_state, w_state_nxt;
    logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
    logic [CKPT_NUM-1:0] r_valid, w_valid_nxt, w_younger;
    logic [TAG_W-1:0]    r_tag       [CKPT_NUM];
    logic                r_color     [CKPT_NUM];
    logic                r_has_ds    [CKPT_NUM];
    logic [PREG_W-1:0]   r_free_head [CKPT_NUM];
    logic [MAP_W-1:0]    r_map       [CKPT_NUM];
    logic [GHR_LEN-1:0]  r_ghr       [CKPT_NUM];

    logic             w_hit, w_res_ok, w_mis, w_alloc_fire;
    logic [IDX_W-1:0] w_hit_idx, w_free_idx;
    logic [TAG_W:0]   w_sq_sum;
    logic             w_sq_wrap, w_sq_color, w_yp_last, w_yc;
    logic [TAG_W-1:0] w_sq_tag, w_yp;

    // Descending scan leaves the lowest matching / free index selected.
    always_comb begin
        w_hit      = 1'b0;
        w_hit_idx  = '0;
        w_free_idx = '0;
        for (int i = CKPT_NUM - 1; i >= 0; i--) begin
            if (!r_valid[i]) w_free_idx = IDX_W'(i);
            if (r_valid[i] && r_tag[i] == resolve_tag && r_color[i] == resolve_color) begin
                w_hit     = 1'b1;
                w_hit_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        w_younger = '0;
        for (int i = 0; i < CKPT_NUM; i++) begin
            w_younger[i] = (r_color[i] == r_color[w_hit_idx]) ? (r_tag[i] > r_tag[w_hit_idx])
                                                              : (r_tag[i] < r_tag[w_hit_idx]);
        end
    end

    assign alloc_ready  = (r_state == S_IDLE) && !(&r_valid) &&
                          !(resolve_valid && resolve_mispredict) && !flush_all;
    assign w_alloc_fire = alloc_valid && alloc_ready;
    assign w_res_ok     = resolve_valid && w_hit && (r_state != S_RECOVER) && !flush_all;
    assign w_mis        = w_res_ok && resolve_mispredict;

    // Squash boundary includes the delay slot; the tail sits just past it.
    assign w_sq_sum   = {1'b0, r_tag[w_hit_idx]} + {{TAG_W{1'b0}}, r_has_ds[w_hit_idx]};
    assign w_sq_wrap  = w_sq_sum >= (TAG_W+1)'(AL_SIZE);
    assign w_sq_tag   = w_sq_wrap ? TAG_W'(w_sq_sum - (TAG_W+1)'(AL_SIZE)) : w_sq_sum[TAG_W-1:0];
    assign w_sq_color = r_color[w_hit_idx] ^ w_sq_wrap;
    assign w_yp_last  = w_sq_tag == TAG_W'(AL_SIZE - 1);
    assign w_yp       = w_yp_last ? '0 : w_sq_tag + TAG_W'(1);
    assign w_yc       = w_sq_color ^ w_yp_last;

    always_comb begin
        w_valid_nxt = r_valid;
        if (w_mis) begin
            w_valid_nxt            = r_valid & ~w_younger;
            w_valid_nxt[w_hit_idx] = 1'b0;
        end else if (w_res_ok) begin
            w_valid_nxt[w_hit_idx] = 1'b0;
        end
        if (w_alloc_fire) w_valid_nxt[w_free_idx] = 1'b1;
        if (flush_all) w_valid_nxt = '0;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (flush_all) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
        end else if (w_mis) begin
            w_state_nxt = S_RECOVER;
        end else begin
            case (r_state)
                S_RECOVER: begin
                    w_state_nxt = S_HOLD;
                    w_cnt_nxt   = CNT_W'(DRAIN_CYCLES - 1);
                end
                S_HOLD: begin
                    if (r_cnt == '0) w_state_nxt = S_IDLE;
                    else             w_cnt_nxt   = r_cnt - CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_valid <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_valid <= w_valid_nxt;
        end
    end

    // Snapshot payload needs no reset: it is qualified by r_valid.
    always_ff @(posedge clk) begin
        if (w_alloc_fire) begin
            r_tag[w_free_idx]       <= alloc_tag;
            r_color[w_free_idx]     <= alloc_color;
            r_has_ds[w_free_idx]    <= alloc_has_ds;
            r_free_head[w_free_idx] <= alloc_free_head;
            r_map[w_free_idx]       <= alloc_map;
            r_ghr[w_free_idx]       <= alloc_ghr;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            restore_free_head <= '0;
            restore_map       <= '0;
            restore_ghr       <= '0;
            squash_tag        <= '0;
            squash_color      <= 1'b0;
            youngest_ptr      <= '0;
            youngest_color    <= 1'b0;
        end else if (w_mis) begin
            restore_free_head <= r_free_head[w_hit_idx];
            restore_map       <= r_map[w_hit_idx];
            restore_ghr       <= {r_ghr[w_hit_idx][GHR_LEN-1:1], ~r_ghr[w_hit_idx][0]};
            squash_tag        <= w_sq_tag;
            squash_color      <= w_sq_color;
            youngest_ptr      <= w_yp;
            youngest_color    <= w_yc;
        end
    end

    assign restore_valid = (r_state == S_RECOVER);
    assign busy          = (r_state != S_IDLE);
    assign ckpt_valid    = r_valid;

`ifdef BRANCH_CKPT_STATS_EN
    logic [31:0] r_stat_mis, r_stat_stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stat_mis   <= '0;
            r_stat_stall <= '0;
        end else begin
            if (w_mis && r_stat_mis != '1) r_stat_mis <= r_stat_mis + 32'd1;
            if (alloc_valid && (&r_valid) && r_state == S_IDLE && r_stat_stall != '1)
                r_stat_stall <= r_stat_stall + 32'd1;
        end
    end

    assign stat_mispredicts = r_stat_mis;
    assign stat_full_stalls = r_stat_stall;
`endif

endmodule

// File: tb/tb_branch_checkpoint_unit.sv
// tb/tb_branch_checkpoint_unit.sv - directed and random checks of branch_checkpoint_unit against a table model
module tb_branch_checkpoint_unit;
    localparam int CK = 4, AL = 32, PW = 6, AR = 32, GL = 8, DR = 2, TW = 5, MW = AR * PW;

    logic clk = 1'b0, rst;
    logic alloc_valid, alloc_color, alloc_has_ds;
    logic [TW-1:0] alloc_tag, resolve_tag;
    logic [PW-1:0] alloc_free_head;
    logic [MW-1:0] alloc_map;
    logic [GL-1:0] alloc_ghr;
    logic resolve_valid, resolve_color, resolve_mispredict, flush_all;
    logic alloc_ready, restore_valid, squash_color, youngest_color, busy;
    logic [PW-1:0] restore_free_head;
    logic [MW-1:0] restore_map;
    logic [GL-1:0] restore_ghr;
    logic [TW-1:0] squash_tag, youngest_ptr;
    logic [CK-1:0] ckpt_valid;
`ifdef BRANCH_CKPT_STATS_EN
    logic [31:0] stat_mispredicts, stat_full_stalls;
`endif

    branch_checkpoint_unit dut (
        .clk(clk), .rst(rst),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
        .alloc_color(alloc_color), .alloc_has_ds(alloc_has_ds), .alloc_free_head(alloc_free_head),
        .alloc_map(alloc_map), .alloc_ghr(alloc_ghr),
        .resolve_valid(resolve_valid), .resolve_tag(resolve_tag), .resolve_color(resolve_color),
        .resolve_mispredict(resolve_mispredict), .flush_all(flush_all),
        .restore_valid(restore_valid), .restore_free_head(restore_free_head),
        .restore_map(restore_map), .restore_ghr(restore_ghr),
        .squash_tag(squash_tag), .squash_color(squash_color),
        .youngest_ptr(youngest_ptr), .youngest_color(youngest_color),
        .busy(busy), .ckpt_valid(ckpt_valid)
`ifdef BRANCH_CKPT_STATS_EN
        , .stat_mispredicts(stat_mispredicts), .stat_full_stalls(stat_full_stalls)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: checkpoint slots plus a countdown of remaining busy cycles.
    bit            m_v   [CK];
    int            m_tag [CK];
    bit            m_col [CK];
    bit            m_ds  [CK];
    logic [PW-1:0] m_fh  [CK];
    logic [MW-1:0] m_map [CK];
    logic [GL-1:0] m_ghr [CK];
    int            mbusy;
    logic [PW-1:0] e_fh;
    logic [MW-1:0] e_map;
    logic [GL-1:0] e_ghr;
    int            e_sqt, e_yp;
    bit            e_sqc, e_yc;
    int            m_stat_mis, m_stat_stall;
    bit            acc_alloc, acc_mis;
    int            n_checks = 0, n_err = 0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic bit younger(int ta, bit ca, int tb, bit cb);
        return (ca == cb) ? (ta > tb) : (ta < tb);
    endfunction

    function automatic logic [MW-1:0] rand_map();
        logic [MW-1:0] r = '0;
        for (int k = 0; k < MW / 32; k++) r = {r[MW-33:0], 32'($urandom)};
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < CK; i++) m_v[i] = 0;
        mbusy = 0; e_fh = '0; e_map = '0; e_ghr = '0;
        e_sqt = 0; e_sqc = 0; e_yp = 0; e_yc = 0;
        m_stat_mis = 0; m_stat_stall = 0;
    endtask

    function automatic bit all_valid();
        for (int i = 0; i < CK; i++) if (!m_v[i]) return 0;
        return 1;
    endfunction

    function automatic bit model_ready();
        return (mbusy == 0) && !all_valid() && !(resolve_valid && resolve_mispredict) && !flush_all;
    endfunction

    task automatic model_step();
        bit rdy, old_v[CK];
        int hit, nb, sum;
        rdy = model_ready();
        acc_alloc = 0; acc_mis = 0;
        if (alloc_valid && all_valid() && mbusy == 0) m_stat_stall++;
        if (flush_all) begin
            for (int i = 0; i < CK; i++) m_v[i] = 0;
            mbusy = 0;
            return;
        end
        old_v = m_v;
        hit = -1;
        for (int i = 0; i < CK; i++)
            if (m_v[i] && m_tag[i] == int'(resolve_tag) && m_col[i] == resolve_color) hit = i;
        nb = (mbusy > 0) ? mbusy - 1 : 0;
        if (resolve_valid && hit >= 0 && mbusy != 1 + DR) begin
            if (resolve_mispredict) begin
                for (int i = 0; i < CK; i++)
                    if (m_v[i] && younger(m_tag[i], m_col[i], m_tag[hit], m_col[hit])) m_v[i] = 0;
                m_v[hit] = 0;
                e_fh = m_fh[hit]; e_map = m_map[hit];
                e_ghr = m_ghr[hit] ^ GL'(1);
                sum = m_tag[hit] + int'(m_ds[hit]);
                e_sqt = sum % AL;
                e_sqc = m_col[hit] ^ (sum >= AL);
                e_yp = (e_sqt + 1) % AL;
                e_yc = e_sqc ^ (e_sqt == AL - 1);
                nb = 1 + DR;
                acc_mis = 1;
                m_stat_mis++;
            end else begin
                m_v[hit] = 0;
            end
        end
        if (alloc_valid && rdy) begin
            for (int i = 0; i < CK; i++) begin
                if (!old_v[i]) begin
                    m_v[i] = 1; m_tag[i] = int'(alloc_tag); m_col[i] = alloc_color;
                    m_ds[i] = alloc_has_ds; m_fh[i] = alloc_free_head;
                    m_map[i] = alloc_map; m_ghr[i] = alloc_ghr;
                    acc_alloc = 1;
                    break;
                end
            end
        end
        mbusy = nb;
    endtask

    task automatic check_outputs();
        logic [CK-1:0] mask;
        for (int i = 0; i < CK; i++) mask[i] = m_v[i];
        chk("ckpt_valid", ckpt_valid, mask);
        chk("busy", busy, mbusy != 0);
        chk("restore_valid", restore_valid, mbusy == 1 + DR);
        chk("restore_free_head", restore_free_head, e_fh);
        chk("restore_map", restore_map, e_map);
        chk("restore_ghr", restore_ghr, e_ghr);
        chk("squash_tag", squash_tag, e_sqt);
        chk("squash_color", squash_color, e_sqc);
        chk("youngest_ptr", youngest_ptr, e_yp);
        chk("youngest_color", youngest_color, e_yc);
`ifdef BRANCH_CKPT_STATS_EN
        chk("stat_mispredicts", stat_mispredicts, m_stat_mis);
        chk("stat_full_stalls", stat_full_stalls, m_stat_stall);
`endif
    endtask

    // Called just after a falling edge with inputs already driven.
    task automatic tick(input bit lit_en, input bit lit_ready);
        #1;
        chk("alloc_ready", alloc_ready, model_ready());
        if (lit_en) chk("lit_alloc_ready", alloc_ready, lit_ready);
        model_step();
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic clear_inputs();
        alloc_valid = 0; alloc_tag = '0; alloc_color = 0; alloc_has_ds = 0;
        alloc_free_head = '0; alloc_map = '0; alloc_ghr = '0;
        resolve_valid = 0; resolve_tag = '0; resolve_color = 0; resolve_mispredict = 0;
        flush_all = 0;
    endtask

    task automatic set_alloc(input int tag, input bit col, input bit ds, input logic [GL-1:0] ghr,
                             input logic [PW-1:0] fh);
        alloc_valid = 1; alloc_tag = TW'(tag); alloc_color = col; alloc_has_ds = ds;
        alloc_ghr = ghr; alloc_free_head = fh; alloc_map = rand_map();
    endtask

    task automatic do_alloc(input int tag, input bit col, input bit ds, input logic [GL-1:0] ghr,
                            input logic [PW-1:0] fh);
        @(negedge clk); clear_inputs(); set_alloc(tag, col, ds, ghr, fh); tick(0, 0);
    endtask

    task automatic do_resolve(input int tag, input bit col, input bit mis);
        @(negedge clk); clear_inputs();
        resolve_valid = 1; resolve_tag = TW'(tag); resolve_color = col; resolve_mispredict = mis;
        tick(0, 0);
    endtask

    task automatic idle_cycle();
        @(negedge clk); clear_inputs(); tick(0, 0);
    endtask

    task automatic flush_cycle();
        @(negedge clk); clear_inputs(); flush_all = 1; tick(0, 0);
    endtask

    int  g_tag;
    bit  g_col;

    initial begin
        clear_inputs();
        rst = 1;
        model_reset();
        #2;
        check_outputs();
        chk("lit_reset_ckpt", ckpt_valid, 0);
        chk("lit_reset_busy", busy, 0);
        @(negedge clk); rst = 0;

        do_alloc(3, 0, 0, 8'h11, 6'd1);
        do_alloc(7, 0, 1, 8'hA5, 6'd2);
        do_alloc(9, 0, 0, 8'h22, 6'd3);
        do_alloc(12, 0, 0, 8'h33, 6'd4);
        chk("lit_full_mask", ckpt_valid, 4'b1111);
        @(negedge clk); clear_inputs(); set_alloc(15, 0, 0, 8'h44, 6'd7);
        for (int k = 0; k < 2; k++) begin
            if (k > 0) @(negedge clk);
            tick(1, 0);
        end
        do_resolve(7, 0, 0);
        chk("lit_free_entry1", ckpt_valid, 4'b1101);
        do_alloc(15, 0, 0, 8'h44, 6'd7);
        chk("lit_refill_entry1", ckpt_valid, 4'b1111);

        flush_cycle();
        chk("lit_flush_mask", ckpt_valid, 0);
        do_alloc(3, 0, 0, 8'h11, 6'd1);
        do_alloc(7, 0, 1, 8'hA5, 6'd2);
        do_alloc(9, 0, 0, 8'h22, 6'd3);
        do_alloc(12, 0, 0, 8'h33, 6'd4);
        @(negedge clk); clear_inputs(); set_alloc(20, 0, 0, 8'h55, 6'd8);
        resolve_valid = 1; resolve_tag = 5'd7; resolve_color = 0; resolve_mispredict = 1;
        tick(1, 0);
        chk("lit_mis_restore_valid", restore_valid, 1);
        chk("lit_mis_ghr", restore_ghr, 8'hA4);
        chk("lit_mis_free_head", restore_free_head, 2);
        chk("lit_mis_squash_tag", squash_tag, 8);
        chk("lit_mis_youngest_ptr", youngest_ptr, 9);
        chk("lit_mis_mask", ckpt_valid, 4'b0001);
        idle_cycle(); chk("lit_hold1_busy", busy, 1); chk("lit_hold1_rv", restore_valid, 0);
        idle_cycle(); chk("lit_hold2_busy", busy, 1);
        idle_cycle(); chk("lit_idle_busy", busy, 0);

        flush_cycle();
        do_alloc(30, 1, 0, 8'h12, 6'd3);
        do_alloc(31, 1, 1, 8'h0F, 6'd6);
        do_resolve(31, 1, 1);
        chk("lit_wrap_squash_tag", squash_tag, 0);
        chk("lit_wrap_squash_color", squash_color, 0);
        chk("lit_wrap_youngest_ptr", youngest_ptr, 1);
        chk("lit_wrap_youngest_color", youngest_color, 0);
        chk("lit_wrap_ghr", restore_ghr, 8'h0E);
        for (int k = 0; k < 3; k++) idle_cycle();

        flush_cycle();
        do_alloc(3, 0, 0, 8'h3C, 6'd5);
        do_alloc(5, 0, 0, 8'h77, 6'd9);
        do_resolve(5, 0, 1);
        idle_cycle();
        @(negedge clk); clear_inputs(); set_alloc(6, 0, 0, 8'h01, 6'd1);
        resolve_valid = 1; resolve_tag = 5'd3; resolve_color = 0; resolve_mispredict = 1;
        tick(1, 0);
        chk("lit_rerecover_rv", restore_valid, 1);
        chk("lit_rerecover_ghr", restore_ghr, 8'h3D);
        chk("lit_rerecover_fh", restore_free_head, 5);
        chk("lit_rerecover_sq", squash_tag, 3);
        chk("lit_rerecover_mask", ckpt_valid, 0);
        for (int k = 0; k < 3; k++) idle_cycle();

        do_alloc(10, 0, 0, 8'h0A, 6'd2);
        do_resolve(10, 0, 1);
        flush_cycle();
        chk("lit_flush_rec_rv", restore_valid, 0);
        chk("lit_flush_rec_busy", busy, 0);

        do_alloc(12, 0, 0, 8'h0C, 6'd2);
        do_resolve(12, 0, 1);
        idle_cycle();
        @(negedge clk); clear_inputs();
        #2 rst = 1;
        #1 model_reset();
        check_outputs();
        chk("lit_rst_busy", busy, 0);
        chk("lit_rst_rv", restore_valid, 0);
        chk("lit_rst_sq", squash_tag, 0);
        @(negedge clk); rst = 0;

        g_tag = 0; g_col = 0;
        for (int c = 0; c < 3000; c++) begin
            int k;
            @(negedge clk); clear_inputs();
            if ($urandom_range(0, 99) < 3) flush_all = 1;
            if ($urandom_range(0, 1) == 1)
                set_alloc(g_tag, g_col, 1'($urandom), GL'($urandom), PW'($urandom));
            if ($urandom_range(0, 2) == 0) begin
                k = $urandom_range(0, CK - 1);
                resolve_valid = 1;
                resolve_tag   = m_v[k] ? TW'(m_tag[k]) : TW'($urandom);
                resolve_color = m_v[k] ? m_col[k] : 1'($urandom);
                resolve_mispredict = ($urandom_range(0, 3) == 0);
            end
            tick(0, 0);
            if (acc_alloc) begin
                g_tag = g_tag + 1 + int'(alloc_has_ds) + $urandom_range(0, 1);
                if (g_tag >= AL) begin g_tag -= AL; g_col = ~g_col; end
            end
            if (acc_mis) begin g_tag = e_yp; g_col = e_yc; end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
